// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB data-phase response stage that sits after the address
// decoder. It registers the owner of each accepted transfer and returns that
// slave's HRDATA/HREADYOUT/HRESP to the master. Transfers that hit no slave get
// the two-cycle ERROR response from the built-in default slave.
//
// Optional build macro: AHB_RESP_MUX_TIMEOUT_EN
//   When defined, a slave that holds its ready low for TIMEOUT_CYCLES data-phase
//   cycles is dropped for the rest of that transfer. The master then gets the
//   same two-cycle ERROR response as an unmapped access.
module ahb_resp_mux #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [1:0]        htrans,
  input  logic              sel_0,
  input  logic              sel_1,
  input  logic              muxsel,
  input  logic [DATA_W-1:0] hrdata_0,
  input  logic              hreadyout_0,
  input  logic              hresp_0,
  input  logic [DATA_W-1:0] hrdata_1,
  input  logic              hreadyout_1,
  input  logic              hresp_1,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic              hresp
);

  typedef enum logic [1:0] {OWN_NONE, OWN_S0, OWN_S1, OWN_DEF} own_t;
  typedef enum logic [1:0] {ERR_IDLE, ERR_1, ERR_2} err_t;

  own_t dp_own;
  own_t addr_own;
  logic dp_mux;
  err_t err_state;
  err_t err_nxt;
  logic timeout_hit;

  // Decide which owner the address phase now on the bus would get.
  always_comb begin
    // NOTE: give every always_comb output a default first, so no path leaves it
    // unassigned and no latch is inferred.
    addr_own = OWN_NONE;
    if (htrans[1]) begin
      if (sel_0)      addr_own = OWN_S0;
      else if (sel_1) addr_own = OWN_S1;
      else            addr_own = OWN_DEF;
    end
  end

  // Data-phase owner register. It loads only on accepting (hready) edges.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples values from before the edge, whatever the
      // order of the blocks.
      dp_own <= OWN_NONE;
      dp_mux <= 1'b0;
    end else if (hready) begin
      dp_own <= addr_own;
      dp_mux <= muxsel;
    end
  end

  // Default-slave error FSM, state register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) err_state <= ERR_IDLE;
    else        err_state <= err_nxt;
  end

  // Error FSM next state. The ERR2 edge accepts, so a back-to-back unmapped
  // transfer goes straight back to ERR1.
  always_comb begin
    err_nxt = err_state;
    if (hready)                  err_nxt = (addr_own == OWN_DEF) ? ERR_1 : ERR_IDLE;
    else if (err_state == ERR_1) err_nxt = ERR_2;
    else if (timeout_hit)        err_nxt = ERR_1;
  end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             slave_stall;

  // A mapped slave is inserting a wait state and has not been dropped yet.
  always_comb begin
    slave_stall = (err_state == ERR_IDLE) &&
                  (((dp_own == OWN_S0) && !hreadyout_0) ||
                   ((dp_own == OWN_S1) && !hreadyout_1));
    timeout_hit = slave_stall && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Count wait states. The count clears whenever a transfer completes.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)           wait_cnt <= '0;
    else if (hready)      wait_cnt <= '0;
    else if (slave_stall) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  // Without the watchdog a slave may stall for as long as it likes.
  always_comb timeout_hit = 1'b0;
`endif

  // Response mux. The error FSM overrides the owner, so a timed-out slave's
  // late ready never reaches the master.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (err_state)
      ERR_1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ERR_2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: begin
        case (dp_own)
          OWN_S0: begin
            hready = hreadyout_0;
            hresp  = hresp_0;
            hrdata = dp_mux ? hrdata_0 : hrdata_1;
          end
          OWN_S1: begin
            hready = hreadyout_1;
            hresp  = hresp_1;
            hrdata = dp_mux ? hrdata_0 : hrdata_1;
          end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux: directed scenarios from the test plan, then a randomized run
// checked against a transaction-level reference model.
module tb_ahb_resp_mux;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              hclk;
  logic              hreset;
  logic [1:0]        htrans;
  logic              sel_0, sel_1, muxsel;
  logic [DATA_W-1:0] hrdata_0, hrdata_1;
  logic              hreadyout_0, hreadyout_1, hresp_0, hresp_1;
  logic [DATA_W-1:0] hrdata;
  logic              hready, hresp;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_resp_mux #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .hclk(hclk), .hreset(hreset), .htrans(htrans),
    .sel_0(sel_0), .sel_1(sel_1), .muxsel(muxsel),
    .hrdata_0(hrdata_0), .hreadyout_0(hreadyout_0), .hresp_0(hresp_0),
    .hrdata_1(hrdata_1), .hreadyout_1(hreadyout_1), .hresp_1(hresp_1),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic addr(input logic [1:0] t, input logic s0, input logic s1, input logic m);
    htrans = t; sel_0 = s0; sel_1 = s1; muxsel = m;
  endtask

  task automatic tick();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    hrdata_0 = 32'h1111_1111; hreadyout_0 = 1'b1; hresp_0 = 1'b0;
    hrdata_1 = 32'h2222_2222; hreadyout_1 = 1'b1; hresp_1 = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b resp=%b data=%h want 1 0 0", hready, hresp, hrdata);
    end
    tick();
    hreset = 1'b0;
    // Unmapped access, then assert reset while the response is in ERR1.
    addr(2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_pre_err1: got rdy=%b resp=%b data=%h want 0 1 0", hready, hresp, hrdata);
    end
    #2 hreset = 1'b1;
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_err1: got rdy=%b resp=%b data=%h want 1 0 0", hready, hresp, hrdata);
    end
    tick();
    hreset = 1'b0;
    // The first transfer after reset behaves normally.
    addr(2'b10, 1'b0, 1'b1, 1'b0);
    hrdata_1 = 32'hCAFE_0001;
    tick();
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL reset_first_xfer: got rdy=%b resp=%b data=%h want 1 0 cafe0001", hready, hresp, hrdata);
    end
    tick();
  endtask

  task automatic test_slave0_read();
    addr(2'b10, 1'b1, 1'b0, 1'b1);
    hrdata_0 = 32'hDEAD_BEEF; hreadyout_0 = 1'b1; hresp_0 = 1'b0;
    tick();
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL s0_read: got rdy=%b resp=%b data=%h want 1 0 deadbeef", hready, hresp, hrdata);
    end
    tick();
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL s0_then_idle: got rdy=%b resp=%b data=%h want 1 0 0", hready, hresp, hrdata);
    end
  endtask

  task automatic test_slave1_wait();
    tick();
    addr(2'b10, 1'b0, 1'b1, 1'b0);
    hrdata_1 = 32'h1234_5678; hreadyout_1 = 1'b0; hresp_1 = 1'b0;
    tick();
    // A new slave-0 address sits on the bus for the whole wait.
    addr(2'b10, 1'b1, 1'b0, 1'b1);
    hrdata_0 = 32'hA5A5_5A5A; hreadyout_0 = 1'b1; hresp_0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({hready, hresp} !== 2'b00) begin
        n_fail++;
        $display("FAIL s1_wait[%0d]: got rdy=%b resp=%b want 0 0", i, hready, hresp);
      end
      tick();
    end
    hreadyout_1 = 1'b1;
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL s1_done: got rdy=%b resp=%b data=%h want 1 0 12345678", hready, hresp, hrdata);
    end
    tick();
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'hA5A5_5A5A}) begin
      n_fail++;
      $display("FAIL s1_next_addr: got rdy=%b resp=%b data=%h want 1 0 a5a55a5a", hready, hresp, hrdata);
    end
    tick();
  endtask

  task automatic test_unmapped_back_to_back();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b11; want[2] = 2'b01; want[3] = 2'b11;
    addr(2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      // Present the second unmapped transfer through ERR2 of the first.
      if (i >= 2) addr(2'b00, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({hready, hresp, hrdata} !== {want[i], 32'h0}) begin
        n_fail++;
        $display("FAIL unmapped[%0d]: got rdy=%b resp=%b data=%h want %b", i, hready, hresp, hrdata, want[i]);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({hready, hresp} !== 2'b10) begin
      n_fail++;
      $display("FAIL unmapped_end: got rdy=%b resp=%b want 1 0", hready, hresp);
    end
  endtask

  task automatic test_idle_busy();
    hrdata_0 = 32'hFFFF_FFFF; hreadyout_0 = 1'b0; hresp_0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr((i == 0) ? 2'b00 : 2'b01, 1'b1, 1'b0, 1'b1);
      tick();
      #1;
      n_checks++;
      if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL idle_busy[%0d]: got rdy=%b resp=%b data=%h want 1 0 0", i, hready, hresp, hrdata);
      end
    end
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    hreadyout_0 = 1'b1; hresp_0 = 1'b0;
    tick();
  endtask

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  task automatic test_timeout();
    addr(2'b10, 1'b1, 1'b0, 1'b1);
    hrdata_0 = 32'h0BAD_0BAD; hreadyout_0 = 1'b0; hresp_0 = 1'b0;
    tick();
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      n_checks++;
      if ({hready, hresp} !== 2'b00) begin
        n_fail++;
        $display("FAIL timeout_wait[%0d]: got rdy=%b resp=%b want 0 0", i, hready, hresp);
      end
      tick();
    end
    // The slave becomes ready too late and must not be forwarded.
    hreadyout_0 = 1'b1;
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_err1: got rdy=%b resp=%b data=%h want 0 1 0", hready, hresp, hrdata);
    end
    tick();
    addr(2'b10, 1'b1, 1'b0, 1'b1);
    hrdata_0 = 32'h600D_600D;
    #1;
    n_checks++;
    if ({hready, hresp} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_err2: got rdy=%b resp=%b want 1 1", hready, hresp);
    end
    tick();
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({hready, hresp, hrdata} !== {1'b1, 1'b0, 32'h600D_600D}) begin
      n_fail++;
      $display("FAIL timeout_next: got rdy=%b resp=%b data=%h want 1 0 600d600d", hready, hresp, hrdata);
    end
    tick();
  endtask
`endif

  // Randomized traffic against a transaction-level model. The model tracks the
  // transfer now in its data phase (which slave, read mux, how far into the
  // error response, how many waits so far).
  task automatic test_random(input int cycles);
    int          kind;        // 0 none, 1 slave 0, 2 slave 1, 3 error response
    int          err_cycle;
    int          waits;
    logic        mux;
    logic        e_rdy, e_resp;
    logic [31:0] e_data;
    kind = 0; err_cycle = 0; waits = 0; mux = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      addr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      hrdata_0    = $urandom;
      hrdata_1    = $urandom;
      hreadyout_0 = ($urandom_range(0, 3) != 0);
      hreadyout_1 = ($urandom_range(0, 3) != 0);
      hresp_0     = ($urandom_range(0, 7) == 0);
      hresp_1     = ($urandom_range(0, 7) == 0);
      e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'h0;
      if (kind == 1 || kind == 2) begin
        e_rdy  = (kind == 1) ? hreadyout_0 : hreadyout_1;
        e_resp = (kind == 1) ? hresp_0 : hresp_1;
        e_data = mux ? hrdata_0 : hrdata_1;
      end else if (kind == 3) begin
        e_rdy  = (err_cycle == 1);
        e_resp = 1'b1;
      end
      #1;
      n_checks++;
      if ({hready, hresp, hrdata} !== {e_rdy, e_resp, e_data}) begin
        n_fail++;
        $display("FAIL random[%0d]: got rdy=%b resp=%b data=%h want %b %b %h",
                 c, hready, hresp, hrdata, e_rdy, e_resp, e_data);
      end
      if (e_rdy) begin
        if (!htrans[1])  kind = 0;
        else if (sel_0)  kind = 1;
        else if (sel_1)  kind = 2;
        else             kind = 3;
        mux = muxsel; err_cycle = 0; waits = 0;
      end else if (kind == 3) begin
        err_cycle = 1;
      end else begin
        waits++;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        if (waits == TIMEOUT) begin
          kind = 3;
          err_cycle = 0;
        end
`endif
      end
      tick();
    end
    addr(2'b00, 1'b0, 1'b0, 1'b0);
    hreadyout_0 = 1'b1; hreadyout_1 = 1'b1; hresp_0 = 1'b0; hresp_1 = 1'b0;
  endtask

  initial begin
    @(negedge hclk);
    test_reset();
    test_slave0_read();
    test_slave1_wait();
    test_unmapped_back_to_back();
    test_idle_busy();
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    test_timeout();
`endif
    test_random(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
